// File: rtl/add_seq_pkg.sv
// Shared types and sizing helpers for the word-serial wide adder.
package add_seq_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter widths never drop below one bit so degenerate parameters still elaborate.
  function automatic int unsigned idx_w(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic int unsigned wait_w(input int unsigned settle);
    return (settle > 0) ? $clog2(settle + 1) : 1;
  endfunction

endpackage

// File: rtl/adder16_rc.sv
// Combinational 16-bit ripple-carry adder: one full adder per bit, carry from bit i into bit i+1.
module adder16_rc
  import add_seq_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              ci,
  output logic [WORD_W-1:0] s,
  output logic              co
);

  logic [WORD_W:0] carry_c;

  assign carry_c[0] = ci;

  for (genvar i = 0; i < WORD_W; i++) begin : g_fa
    logic p_c;
    assign p_c            = a[i] ^ b[i];
    assign s[i]           = p_c ^ carry_c[i];
    assign carry_c[i + 1] = (a[i] & b[i]) | (p_c & carry_c[i]);
  end

  assign co = carry_c[WORD_W];

endmodule

// File: rtl/wide_add_sequencer.sv
// Adds two WORDS x 16-bit operands one word per step through a single ripple-carry adder,
// least-significant word first, with the inter-word carry held in a register.
module wide_add_sequencer
  import add_seq_pkg::*;
#(
  parameter int unsigned WORDS  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [WORD_W*WORDS-1:0]   a_in,
  input  logic [WORD_W*WORDS-1:0]   b_in,
  input  logic                      cin,
  output logic                      done_valid,
  input  logic                      done_ready,
  output logic [WORD_W*WORDS-1:0]   sum_out,
  output logic                      cout,
  output logic                      busy
);

  localparam int unsigned IDX_W  = idx_w(WORDS);
  localparam int unsigned WAIT_W = wait_w(SETTLE);

  typedef logic [WORDS-1:0][WORD_W-1:0] words_t;

  state_e            state_q, state_d;
  words_t            a_q, a_d;
  words_t            b_q, b_d;
  words_t            sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              start_ready_q, start_ready_d;
  logic              done_valid_q, done_valid_d;
  logic              busy_q, busy_d;

  logic [WORD_W-1:0] add_s;
  logic              add_co;

  adder16_rc u_adder (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .ci (carry_q),
    .s  (add_s),
    .co (add_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      sum_q         <= '0;
      carry_q       <= 1'b0;
      idx_q         <= '0;
      wait_q        <= '0;
      start_ready_q <= 1'b1;
      done_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      sum_q         <= sum_d;
      carry_q       <= carry_d;
      idx_q         <= idx_d;
      wait_q        <= wait_d;
      start_ready_q <= start_ready_d;
      done_valid_q  <= done_valid_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state and datapath updates; handshake flags are registered from the next state.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    wait_d  = wait_q;

    case (state_q)
      IDLE: begin
        if (start_valid && start_ready_q) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          idx_d   = '0;
          wait_d  = '0;
          sum_d   = '0;
          state_d = ADD;
        end
      end

      ADD: begin
        // wait_q counts up to SETTLE and never past it, so inequality is enough.
        if (wait_q != WAIT_W'(SETTLE)) begin
          wait_d = wait_q + WAIT_W'(1);
        end else begin
          sum_d[idx_q] = add_s;
          carry_d      = add_co;
          wait_d       = '0;
          if (idx_q == IDX_W'(WORDS - 1)) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    start_ready_d = (state_d == IDLE);
    done_valid_d  = (state_d == DONE);
    busy_d        = (state_d != IDLE);
  end

  assign start_ready = start_ready_q;
  assign done_valid  = done_valid_q;
  assign busy        = busy_q;
  assign sum_out     = sum_q;
  assign cout        = carry_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench: WORDS=4/SETTLE=1 instance for most scenarios, WORDS=2/SETTLE=0 for the short one.
module tb_wide_add_sequencer;

  logic        clk;
  logic        rst;

  logic        start_valid, start_ready, cin, done_valid, done_ready, cout, busy;
  logic [63:0] a_in, b_in, sum_out;

  logic        start_valid2, start_ready2, cin2, done_valid2, done_ready2, cout2, busy2;
  logic [31:0] a_in2, b_in2, sum_out2;

  int n_tests;
  int n_fail;
  int lat;

  wide_add_sequencer #(.WORDS(4), .SETTLE(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .cin         (cin),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .sum_out     (sum_out),
    .cout        (cout),
    .busy        (busy)
  );

  wide_add_sequencer #(.WORDS(2), .SETTLE(0)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid2),
    .start_ready (start_ready2),
    .a_in        (a_in2),
    .b_in        (b_in2),
    .cin         (cin2),
    .done_valid  (done_valid2),
    .done_ready  (done_ready2),
    .sum_out     (sum_out2),
    .cout        (cout2),
    .busy        (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Accept one operand set on the next edge, then count edges until done_valid (-1 on timeout).
  task automatic run_add(input logic [63:0] a, input logic [63:0] b, input logic ci,
                         output int l);
    a_in = a; b_in = b; cin = ci; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    l = -1;
    for (int k = 0; k < 40; k++) begin
      if (done_valid) begin
        l = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_add2(input logic [31:0] a, input logic [31:0] b, input logic ci,
                          output int l);
    a_in2 = a; b_in2 = b; cin2 = ci; start_valid2 = 1'b1;
    @(posedge clk); #1;
    start_valid2 = 1'b0;
    l = -1;
    for (int k = 0; k < 40; k++) begin
      if (done_valid2) begin
        l = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic take_result();
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
  endtask

  task automatic take_result2();
    done_ready2 = 1'b1;
    @(posedge clk); #1;
    done_ready2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_valid = 1'b1; a_in = 64'h1; b_in = 64'h2; cin = 1'b1;
    start_valid2 = 1'b1; a_in2 = 32'h5; b_in2 = 32'h6; cin2 = 1'b0;
    done_ready = 1'b0; done_ready2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready got=%b exp=1", start_ready); end
    n_tests++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL reset_done_valid got=%b exp=0", done_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (sum_out !== 64'h0) begin n_fail++; $display("FAIL reset_sum got=%h exp=0", sum_out); end
    n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout); end
    n_tests++; if (start_ready2 !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready2 got=%b exp=1", start_ready2); end
    rst = 1'b0; start_valid = 1'b0; start_valid2 = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    run_add(64'h00ED, 64'h016F, 1'b0, lat);
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    n_tests++; if (sum_out !== 64'h0000_0000_0000_025C) begin n_fail++; $display("FAIL basic_sum got=%h exp=%h", sum_out, 64'h25C); end
    n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL basic_cout got=%b exp=0", cout); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_in_done got=%b exp=1", busy); end
    take_result();
    n_tests++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL basic_back_to_idle got=%b exp=1", start_ready); end
  endtask

  task automatic test_inter_word_carry();
    run_add(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, lat);
    n_tests++; if (sum_out !== 64'h0000_0000_0001_0000) begin n_fail++; $display("FAIL carry_sum got=%h exp=%h", sum_out, 64'h10000); end
    n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL carry_cout got=%b exp=0", cout); end
    take_result();
  endtask

  task automatic test_full_wrap();
    run_add(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, lat);
    n_tests++; if (sum_out !== 64'h0) begin n_fail++; $display("FAIL wrap_sum got=%h exp=0", sum_out); end
    n_tests++; if (cout !== 1'b1) begin n_fail++; $display("FAIL wrap_cout got=%b exp=1", cout); end
    take_result();
  endtask

  task automatic test_back_to_back();
    run_add(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0, lat);
    n_tests++; if (sum_out !== 64'h1111_1111_1111_1100) begin n_fail++; $display("FAIL b2b_first_sum got=%h exp=%h", sum_out, 64'h1111_1111_1111_1100); end
    n_tests++; if (cout !== 1'b1) begin n_fail++; $display("FAIL b2b_first_cout got=%b exp=1", cout); end
    take_result();
    n_tests++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b exp=1", start_ready); end
    run_add(64'h0000_8000_0000_0001, 64'h0000_8000_0000_0002, 1'b1, lat);
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=8", lat); end
    n_tests++; if (sum_out !== 64'h0001_0000_0000_0004) begin n_fail++; $display("FAIL b2b_second_sum got=%h exp=%h", sum_out, 64'h0001_0000_0000_0004); end
    take_result();
  endtask

  task automatic test_backpressure();
    run_add(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      start_valid = ~start_valid;
      a_in = ~a_in;
      @(posedge clk); #1;
      n_tests++; if (done_valid !== 1'b1) begin n_fail++; $display("FAIL bp_done_valid cyc=%0d got=%b exp=1", i, done_valid); end
      n_tests++; if (sum_out !== 64'h0011_0022_0033_0044) begin n_fail++; $display("FAIL bp_sum cyc=%0d got=%h exp=%h", i, sum_out, 64'h0011_0022_0033_0044); end
      n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL bp_cout cyc=%0d got=%b exp=0", i, cout); end
      n_tests++; if (start_ready !== 1'b0) begin n_fail++; $display("FAIL bp_start_ready cyc=%0d got=%b exp=0", i, start_ready); end
    end
    a_in = 64'hAAAA_AAAA_AAAA_AAAA; b_in = 64'h5555_5555_5555_5555; cin = 1'b1;
    start_valid = 1'b1; done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    n_tests++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_idle got=%b exp=1", start_ready); end
    n_tests++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_done got=%b exp=0", done_valid); end
    @(posedge clk); #1;
    start_valid = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_next_accept busy got=%b exp=1", busy); end
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (done_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL bp_next_latency got=%0d exp=8", lat); end
    n_tests++; if (sum_out !== 64'h0) begin n_fail++; $display("FAIL bp_next_sum got=%h exp=0", sum_out); end
    n_tests++; if (cout !== 1'b1) begin n_fail++; $display("FAIL bp_next_cout got=%b exp=1", cout); end
    take_result();
  endtask

  task automatic test_reset_mid();
    int seen;
    a_in = 64'h0000_0000_1111_1111; b_in = 64'h0000_0000_2222_2222; cin = 1'b0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++; if (sum_out !== 64'h0000_0000_0000_3333) begin n_fail++; $display("FAIL mid_partial got=%h exp=%h", sum_out, 64'h3333); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL mid_start_ready got=%b exp=1", start_ready); end
    n_tests++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL mid_done_valid got=%b exp=0", done_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", busy); end
    n_tests++; if (sum_out !== 64'h0) begin n_fail++; $display("FAIL mid_sum got=%h exp=0", sum_out); end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (done_valid) seen++;
      @(posedge clk); #1;
    end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL mid_no_done got=%0d exp=0", seen); end
    run_add(64'd123, 64'd723, 1'b0, lat);
    n_tests++; if (sum_out !== 64'h034E) begin n_fail++; $display("FAIL mid_followup_sum got=%h exp=%h", sum_out, 64'h34E); end
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL mid_followup_latency got=%0d exp=8", lat); end
    take_result();
  endtask

  task automatic test_settle0();
    run_add2(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL s0_latency got=%0d exp=2", lat); end
    n_tests++; if (sum_out2 !== 32'h0) begin n_fail++; $display("FAIL s0_sum got=%h exp=0", sum_out2); end
    n_tests++; if (cout2 !== 1'b1) begin n_fail++; $display("FAIL s0_cout got=%b exp=1", cout2); end
    take_result2();
    run_add2(32'h0000_FFFF, 32'h0000_0001, 1'b0, lat);
    n_tests++; if (sum_out2 !== 32'h0001_0000) begin n_fail++; $display("FAIL s0_carry_sum got=%h exp=%h", sum_out2, 32'h10000); end
    n_tests++; if (cout2 !== 1'b0) begin n_fail++; $display("FAIL s0_carry_cout got=%b exp=0", cout2); end
    take_result2();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    start_valid = 1'b0; a_in = '0; b_in = '0; cin = 1'b0; done_ready = 1'b0;
    start_valid2 = 1'b0; a_in2 = '0; b_in2 = '0; cin2 = 1'b0; done_ready2 = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_inter_word_carry();
    test_full_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_settle0();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
